// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port unified memory between the IF-stage instruction
//   fetch and the MEM-stage load/store.  Every access runs through a fixed
//   command / wait / response sequence, and a pipeline-wide stall is raised
//   while any request is still waiting for its grant.
//
//   State table
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | no access in flight; accept d_req first, otherwise if_req
//   CMD   | mem_en high for one cycle; stores go on to RESP, reads to WAIT
//   WAIT  | counting down the read latency; capture mem_rdata at cnt==1
//   RESP  | one-cycle grant to the owner; always returns to IDLE
//
// Parameters
//   LAT  memory read latency, mem_en cycle to data-valid cycle (1..15)
//   AW   address width
//   DW   data width
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   if_req     fetch request, held with if_addr until if_gnt
//   if_addr    fetch address
//   if_gnt     one-cycle grant pulse, if_rdata valid
//   if_rdata   fetched instruction
//   d_req      data request, held with d_we/d_addr/d_wdata until d_gnt
//   d_we       1 = store, 0 = load
//   d_addr     data address
//   d_wdata    store data
//   d_gnt      one-cycle grant pulse, d_rdata valid for loads
//   d_rdata    load data
//   mem_en     memory command strobe, one cycle per access
//   mem_we     memory write enable, qualified by mem_en
//   mem_addr   memory address (held after the command)
//   mem_wdata  memory write data (held after the command)
//   mem_rdata  memory read data, valid LAT cycles after the mem_en cycle
//   stall      combinational: a request is pending without its grant

module mem_port_arbiter #(
    parameter int LAT = 2,
    parameter int AW  = 32,
    parameter int DW  = 32
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic [DW-1:0] if_rdata,

    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic [DW-1:0] d_rdata,

    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,

    output logic          stall
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam int CW = 4;

    state_t        state;
    logic          owner_d;   // 1 = MEM-stage data port, 0 = IF-stage fetch
    logic [CW-1:0] cnt;

    // Everything except stall is registered.  mem_en/mem_we and the grants
    // default low each cycle and are raised only on the edge that enters the
    // state in which they must be visible (CMD for the strobe, RESP for gnt).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            owner_d   <= 1'b0;
            cnt       <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_gnt    <= 1'b0;
            d_gnt     <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
        end else begin
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            if_gnt <= 1'b0;
            d_gnt  <= 1'b0;

            case (state)
                IDLE: begin
                    // Data port wins a tie: MEM holds the older instruction.
                    if (d_req) begin
                        owner_d   <= 1'b1;
                        mem_en    <= 1'b1;
                        mem_we    <= d_we;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                        state     <= CMD;
                    end else if (if_req) begin
                        owner_d  <= 1'b0;
                        mem_en   <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= if_addr;
                        state    <= CMD;
                    end
                end

                CMD: begin
                    // mem_we is high in CMD exactly when this is a store.
                    if (mem_we) begin
                        d_gnt <= 1'b1;
                        state <= RESP;
                    end else begin
                        cnt   <= CW'(LAT);
                        state <= WAIT;
                    end
                end

                WAIT: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        if (owner_d) begin
                            d_rdata <= mem_rdata;
                            d_gnt   <= 1'b1;
                        end else begin
                            if_rdata <= mem_rdata;
                            if_gnt   <= 1'b1;
                        end
                        state <= RESP;
                    end
                end

                RESP: begin
                    // No back-to-back issue; one IDLE cycle between accesses.
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign stall = (if_req & ~if_gnt) | (d_req & ~d_gnt);

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;

    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;

    logic        if_gnt, d_gnt, mem_en, mem_we, stall;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

    // second instance built with LAT=1, fetch port only
    logic        if1_req = 1'b0;
    logic [31:0] if1_addr = '0;
    logic        if1_gnt, d1_gnt, mem1_en, mem1_we, stall1;
    logic [31:0] if1_rdata, d1_rdata, mem1_addr, mem1_wdata, mem1_rdata;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.LAT(2), .AW(32), .DW(32)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .stall(stall)
    );

    mem_port_arbiter #(.LAT(1), .AW(32), .DW(32)) dut1 (
        .clk(clk), .reset(reset),
        .if_req(if1_req), .if_addr(if1_addr), .if_gnt(if1_gnt), .if_rdata(if1_rdata),
        .d_req(1'b0), .d_we(1'b0), .d_addr(32'h0), .d_wdata(32'h0),
        .d_gnt(d1_gnt), .d_rdata(d1_rdata),
        .mem_en(mem1_en), .mem_we(mem1_we), .mem_addr(mem1_addr),
        .mem_wdata(mem1_wdata), .mem_rdata(mem1_rdata), .stall(stall1)
    );

    // ---------------- memory model ----------------
    bit          wr_v [0:255];
    logic [31:0] wr_d [0:255];
    logic        p1_v = 1'b0, p2_v = 1'b0, q_v = 1'b0;
    logic [31:0] p1_d = '0, p2_d = '0, q_d = '0;

    function automatic logic [31:0] init_word(input logic [31:0] a);
        case (a)
            32'h40:  return 32'h2008_0005;
            32'h80:  return 32'h1234_5678;
            default: return {a[15:0], 16'hA5A5};
        endcase
    endfunction

    function automatic logic [31:0] read_word(input logic [31:0] a);
        if (wr_v[a[9:2]]) return wr_d[a[9:2]];
        return init_word(a);
    endfunction

    always @(posedge clk) begin
        if (mem_en && mem_we) begin
            wr_v[mem_addr[9:2]] <= 1'b1;
            wr_d[mem_addr[9:2]] <= mem_wdata;
        end
        p1_v <= mem_en && !mem_we;
        p1_d <= read_word(mem_addr);
        p2_v <= p1_v;
        p2_d <= p1_d;
        q_v  <= mem1_en && !mem1_we;
        q_d  <= read_word(mem1_addr);
    end

    // Outside the data-valid cycle the memory drives garbage.
    assign mem_rdata  = p2_v ? p2_d : 32'hBAD0_BAD0;
    assign mem1_rdata = q_v  ? q_d  : 32'hBAD1_BAD1;

    // ---------------- tests ----------------
    task automatic test_reset();
        #12;
        n_cmp++; if ({mem_en, mem_we, if_gnt, d_gnt, stall} !== 5'b0) begin
            n_fail++; $display("FAIL reset_ctl: got %b want 00000", {mem_en, mem_we, if_gnt, d_gnt, stall});
        end
        n_cmp++; if ({mem_addr, mem_wdata, if_rdata, d_rdata} !== 128'h0) begin
            n_fail++; $display("FAIL reset_data: got %h want 0", {mem_addr, mem_wdata, if_rdata, d_rdata});
        end
        n_cmp++; if ({mem1_en, if1_gnt, d1_gnt, stall1, mem1_addr, if1_rdata} !== 68'h0) begin
            n_fail++; $display("FAIL reset_dut1: got %h want 0", {mem1_en, if1_gnt, d1_gnt, stall1, mem1_addr, if1_rdata});
        end
        @(negedge clk); reset = 1'b1;
    endtask

    task automatic test_reset_mid_wait();
        @(negedge clk); if_req = 1'b1; if_addr = 32'h40;
        for (int c = 0; c <= 5; c++) begin
            if (c > 0) @(negedge clk);
            if (c == 2) reset = 1'b0;
            #1;
            if (c == 1) begin
                n_cmp++; if (mem_en !== 1'b1) begin
                    n_fail++; $display("FAIL rst_mid_cmd: mem_en got %b want 1", mem_en);
                end
            end
            if (c == 2) begin
                n_cmp++; if ({mem_en, mem_we, if_gnt, d_gnt, mem_addr, mem_wdata, if_rdata, d_rdata} !== 132'h0) begin
                    n_fail++; $display("FAIL rst_mid_zero: got %h want 0", {mem_en, mem_we, if_gnt, d_gnt, mem_addr, mem_wdata, if_rdata, d_rdata});
                end
            end
            if (c >= 2) begin
                n_cmp++; if (stall !== 1'b1) begin
                    n_fail++; $display("FAIL rst_mid_stall c%0d: got %b want 1", c, stall);
                end
                n_cmp++; if (if_gnt !== 1'b0) begin
                    n_fail++; $display("FAIL rst_mid_gnt c%0d: got %b want 0", c, if_gnt);
                end
            end
        end
        @(negedge clk); if_req = 1'b0; reset = 1'b1;
        for (int c = 0; c < 8; c++) begin
            #1;
            n_cmp++; if ({stall, mem_en, if_gnt, d_gnt} !== 4'b0) begin
                n_fail++; $display("FAIL rst_release c%0d: got %b want 0000", c, {stall, mem_en, if_gnt, d_gnt});
            end
            @(negedge clk);
        end
    endtask

    task automatic test_fetch();
        if_req = 1'b1; if_addr = 32'h40;
        for (int c = 0; c <= 5; c++) begin
            if (c > 0) @(negedge clk);
            if (c == 5) if_req = 1'b0;
            #1;
            n_cmp++; if (stall !== (c < 4)) begin
                n_fail++; $display("FAIL fetch_stall c%0d: got %b want %b", c, stall, (c < 4));
            end
            n_cmp++; if (mem_en !== (c == 1)) begin
                n_fail++; $display("FAIL fetch_en c%0d: got %b want %b", c, mem_en, (c == 1));
            end
            n_cmp++; if ({if_gnt, d_gnt} !== {(c == 4), 1'b0}) begin
                n_fail++; $display("FAIL fetch_gnt c%0d: got %b want %b0", c, {if_gnt, d_gnt}, (c == 4));
            end
            if (c == 1) begin
                n_cmp++; if ({mem_we, mem_addr} !== {1'b0, 32'h40}) begin
                    n_fail++; $display("FAIL fetch_cmd: got we=%b addr=%h want we=0 addr=00000040", mem_we, mem_addr);
                end
            end
            if (c == 4) begin
                n_cmp++; if (if_rdata !== 32'h2008_0005) begin
                    n_fail++; $display("FAIL fetch_rdata: got %h want 20080005", if_rdata);
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_store_load();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF;
        for (int c = 0; c <= 3; c++) begin
            if (c > 0) @(negedge clk);
            if (c == 3) d_req = 1'b0;
            #1;
            n_cmp++; if (stall !== (c < 2)) begin
                n_fail++; $display("FAIL store_stall c%0d: got %b want %b", c, stall, (c < 2));
            end
            n_cmp++; if ({mem_en, mem_we} !== {(c == 1), (c == 1)}) begin
                n_fail++; $display("FAIL store_en c%0d: got %b want %b%b", c, {mem_en, mem_we}, (c == 1), (c == 1));
            end
            n_cmp++; if ({d_gnt, if_gnt} !== {(c == 2), 1'b0}) begin
                n_fail++; $display("FAIL store_gnt c%0d: got %b want %b0", c, {d_gnt, if_gnt}, (c == 2));
            end
            if (c == 1) begin
                n_cmp++; if ({mem_addr, mem_wdata} !== {32'h100, 32'hDEAD_BEEF}) begin
                    n_fail++; $display("FAIL store_cmd: got addr=%h wdata=%h want 00000100 deadbeef", mem_addr, mem_wdata);
                end
            end
        end
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100; d_wdata = 32'h0;
        for (int c = 0; c <= 5; c++) begin
            if (c > 0) @(negedge clk);
            if (c == 5) d_req = 1'b0;
            #1;
            n_cmp++; if ({mem_en, mem_we} !== {(c == 1), 1'b0}) begin
                n_fail++; $display("FAIL load_en c%0d: got %b want %b0", c, {mem_en, mem_we}, (c == 1));
            end
            n_cmp++; if ({d_gnt, stall} !== {(c == 4), (c < 4)}) begin
                n_fail++; $display("FAIL load_gnt c%0d: got %b want %b%b", c, {d_gnt, stall}, (c == 4), (c < 4));
            end
            if (c == 4) begin
                n_cmp++; if (d_rdata !== 32'hDEAD_BEEF) begin
                    n_fail++; $display("FAIL load_rdata: got %h want deadbeef", d_rdata);
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_simultaneous();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80;
        if_req = 1'b1; if_addr = 32'hC0;
        for (int c = 0; c <= 10; c++) begin
            if (c > 0) @(negedge clk);
            if (c == 5) d_req = 1'b0;
            if (c == 10) if_req = 1'b0;
            #1;
            n_cmp++; if (stall !== (c <= 8)) begin
                n_fail++; $display("FAIL sim_stall c%0d: got %b want %b", c, stall, (c <= 8));
            end
            n_cmp++; if ({mem_en, mem_we} !== {(c == 1 || c == 6), 1'b0}) begin
                n_fail++; $display("FAIL sim_en c%0d: got %b want %b0", c, {mem_en, mem_we}, (c == 1 || c == 6));
            end
            n_cmp++; if ({d_gnt, if_gnt} !== {(c == 4), (c == 9)}) begin
                n_fail++; $display("FAIL sim_gnt c%0d: got %b want %b%b", c, {d_gnt, if_gnt}, (c == 4), (c == 9));
            end
            if (c == 1) begin
                n_cmp++; if (mem_addr !== 32'h80) begin
                    n_fail++; $display("FAIL sim_d_addr: got %h want 00000080", mem_addr);
                end
            end
            if (c == 6) begin
                n_cmp++; if (mem_addr !== 32'hC0) begin
                    n_fail++; $display("FAIL sim_i_addr: got %h want 000000c0", mem_addr);
                end
            end
            if (c == 4) begin
                n_cmp++; if (d_rdata !== 32'h1234_5678) begin
                    n_fail++; $display("FAIL sim_d_rdata: got %h want 12345678", d_rdata);
                end
            end
            if (c == 9) begin
                n_cmp++; if (if_rdata !== 32'h00C0_A5A5) begin
                    n_fail++; $display("FAIL sim_i_rdata: got %h want 00c0a5a5", if_rdata);
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_mid_change();
        if_req = 1'b1; if_addr = 32'h40;
        for (int c = 0; c <= 5; c++) begin
            if (c > 0) @(negedge clk);
            if (c == 2) if_addr = 32'h80;
            if (c == 5) if_req = 1'b0;
            #1;
            if (c >= 1 && c <= 4) begin
                n_cmp++; if (mem_addr !== 32'h40) begin
                    n_fail++; $display("FAIL chg_addr c%0d: got %h want 00000040", c, mem_addr);
                end
            end
            n_cmp++; if (if_gnt !== (c == 4)) begin
                n_fail++; $display("FAIL chg_gnt c%0d: got %b want %b", c, if_gnt, (c == 4));
            end
            if (c == 4) begin
                n_cmp++; if (if_rdata !== 32'h2008_0005) begin
                    n_fail++; $display("FAIL chg_rdata: got %h want 20080005", if_rdata);
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_lat1();
        if1_req = 1'b1; if1_addr = 32'h80;
        for (int c = 0; c <= 4; c++) begin
            if (c > 0) @(negedge clk);
            if (c == 4) if1_req = 1'b0;
            #1;
            n_cmp++; if (stall1 !== (c < 3)) begin
                n_fail++; $display("FAIL lat1_stall c%0d: got %b want %b", c, stall1, (c < 3));
            end
            n_cmp++; if (mem1_en !== (c == 1)) begin
                n_fail++; $display("FAIL lat1_en c%0d: got %b want %b", c, mem1_en, (c == 1));
            end
            n_cmp++; if (if1_gnt !== (c == 3)) begin
                n_fail++; $display("FAIL lat1_gnt c%0d: got %b want %b", c, if1_gnt, (c == 3));
            end
            if (c == 3) begin
                n_cmp++; if (if1_rdata !== 32'h1234_5678) begin
                    n_fail++; $display("FAIL lat1_rdata: got %h want 12345678", if1_rdata);
                end
            end
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_reset_mid_wait();
        test_fetch();
        test_store_load();
        test_simultaneous();
        test_mid_change();
        test_lat1();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-port unified memory between the IF-stage instruction fetch and the MEM-stage load/store.
It sequences each access through a fixed-latency command/wait/response FSM and raises a pipeline-wide stall while any access is outstanding.
It sits between if_stage/mem_stage and the memory macro, and is instantiated in top.

Parameters:
LAT, 2, memory read latency in cycles from the command cycle to the data-valid cycle; legal range 1..15.
AW, 32, address width.
DW, 32, data width.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
if_req  in  1  fetch request; held high, with if_addr stable, until if_gnt
if_addr  in  AW  fetch address
if_gnt  out  1  one-cycle pulse; if_rdata valid this cycle
if_rdata  out  DW  fetched instruction
d_req  in  1  data request; held high, with d_we/d_addr/d_wdata stable, until d_gnt
d_we  in  1  1 = store, 0 = load
d_addr  in  AW  data address
d_wdata  in  DW  store data
d_gnt  out  1  one-cycle pulse; d_rdata valid this cycle for loads
d_rdata  out  DW  load data
mem_en  out  1  memory command strobe, one cycle per access
mem_we  out  1  memory write enable, qualified by mem_en
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data, valid LAT cycles after the mem_en cycle
stall  out  1  combinational: (if_req & ~if_gnt) | (d_req & ~d_gnt)

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset (reset=0): FSM to IDLE and owner cleared. mem_en, mem_we, if_gnt and d_gnt are 0. mem_addr, mem_wdata, if_rdata and d_rdata are 0. Wait counter is 0.
- Reset mid-transaction: the transaction is discarded and no gnt is issued. The stall output still follows the requests.
- All outputs except stall are registered.
- FSM states: IDLE, CMD, WAIT, RESP.
- IDLE:
  - At the clock edge, if d_req=1, latch owner=D, mem_we=d_we, mem_addr=d_addr, mem_wdata=d_wdata, then go to CMD.
  - Otherwise, if if_req=1, latch owner=I, mem_we=0, mem_addr=if_addr, then go to CMD.
  - Otherwise stay in IDLE.
- Priority: D always wins a simultaneous request, because MEM holds the older instruction. IF cannot starve: d_req deasserts after d_gnt while the pipeline is frozen.
- CMD (exactly 1 cycle):
  - mem_en=1.
  - For a store, go next to RESP.
  - For a load or fetch, load cnt=LAT and go to WAIT.
- WAIT (LAT cycles):
  - cnt decrements every cycle.
  - In the cycle with cnt==1, mem_rdata is valid. At that edge, capture it into d_rdata or if_rdata per the owner, then go to RESP.
- RESP (1 cycle):
  - The owner's gnt=1.
  - Next state is IDLE unconditionally. There is no back-to-back issue: at least one IDLE cycle separates accesses.
- mem_en and mem_we are 0 outside CMD. mem_addr and mem_wdata hold their last value.
- The rdata registers hold their value until overwritten by the next access of the same owner.
- Latency:
  - Request first seen in IDLE cycle 0.
  - Load or fetch gnt in cycle LAT+2.
  - Store gnt in cycle 2.
- Protocol violation (req dropped before gnt): the transaction still completes and gnt still pulses. The requester ignores it.
- Changes to addr/data after acceptance are ignored; the latched copy is used.
- stall is also high in IDLE and CMD while a request is pending. It is low in the RESP cycle if no other request is pending.

Test Plan:
- Reset: assert reset=0 mid-WAIT -> all registered outputs 0, FSM IDLE, no gnt. Release with no requests -> stall=0, mem_en never pulses.
- Fetch, LAT=2: if_req=1, if_addr=0x0000_0040, mem model returns 0x2008_0005 -> mem_en=1, mem_we=0, mem_addr=0x40 in cycle 1. if_gnt=1 with if_rdata=0x2008_0005 in cycle 4. stall=1 in cycles 0-3, 0 in cycle 4.
- Store: d_req=1, d_we=1, d_addr=0x100, d_wdata=0xDEAD_BEEF -> cycle 1 mem_en=1, mem_we=1, mem_wdata=0xDEADBEEF. d_gnt in cycle 2. A subsequent load of 0x100 returns 0xDEADBEEF.
- Simultaneous: if_req and d_req (load) rise in the same cycle -> D served first, d_gnt in cycle 4. One IDLE cycle (cycle 5). IF command in cycle 6, if_gnt in cycle 9. stall=1 in cycles 0-8, 0 in cycle 9.
- LAT=1 build: fetch -> if_gnt in cycle 3. Capture happens on the first WAIT cycle.
- Mid-access change: if_addr changes from 0x40 to 0x80 during WAIT -> mem_addr stays 0x40 and if_rdata is the data for 0x40.
